// File: rtl/td4_pkg.sv
// td4_pkg: shared opcodes, ALU select codes,
// load-enable bit positions and sequencer states.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_IN = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int LD_A = 0;
  localparam int LD_B = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC = 3;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_t;

endpackage

// File: rtl/td4_op_decode.sv
// td4_op_decode: combinational opcode table
// giving ALU select, load enables and flags.
module td4_op_decode
  import td4_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic       i_carry,
  output logic [1:0] o_sel,
  output logic [3:0] o_load,
  output logic       o_is_add,
  output logic       o_is_illegal
);

  // opcode to control lines
  always_comb begin
    o_sel = SEL_ZERO;
    o_load = '0;
    o_is_add = 1'b0;
    o_is_illegal = 1'b0;
    unique case (i_op)
      OP_MOV_AI: o_load[LD_A] = 1'b1;
      OP_MOV_BI: o_load[LD_B] = 1'b1;
      OP_MOV_AB: begin
        o_sel = SEL_B;
        o_load[LD_A] = 1'b1;
      end
      OP_MOV_BA: begin
        o_sel = SEL_A;
        o_load[LD_B] = 1'b1;
      end
      OP_ADD_A: begin
        o_sel = SEL_A;
        o_load[LD_A] = 1'b1;
        o_is_add = 1'b1;
      end
      OP_ADD_B: begin
        o_sel = SEL_B;
        o_load[LD_B] = 1'b1;
        o_is_add = 1'b1;
      end
      OP_IN_A: begin
        o_sel = SEL_IN;
        o_load[LD_A] = 1'b1;
      end
      OP_IN_B: begin
        o_sel = SEL_IN;
        o_load[LD_B] = 1'b1;
      end
      OP_OUT_I: o_load[LD_OUT] = 1'b1;
      OP_OUT_B: begin
        o_sel = SEL_B;
        o_load[LD_OUT] = 1'b1;
      end
      OP_JMP: o_load[LD_PC] = 1'b1;
      OP_JNC: o_load[LD_PC] = ~i_carry;
      default: o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/td4_ctrl_seq.sv
// td4_ctrl_seq: fetch/decode/execute control
// sequencer with carry flag and illegal trap.
module td4_ctrl_seq
  import td4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [4+DATA_W-1:0] instr_data,
  output logic                instr_ready,
  input  logic                carry_in,
  output logic [1:0]          sel,
  output logic [DATA_W-1:0]   imm,
  output logic [3:0]          load,
  output logic                pc_inc,
  output logic                carry_flag,
  output logic                illegal,
  output logic                halted
);

  localparam int IW = 4 + DATA_W;

  state_t            r_state;
  logic [IW-1:0]     r_ir;
  logic [1:0]        r_sel;
  logic [3:0]        r_load;
  logic              r_pc_inc;
  logic              r_illegal;
  logic              r_is_add;
  logic              r_carry;

  logic              w_accept;
  logic [3:0]        w_op;
  logic [1:0]        w_sel;
  logic [3:0]        w_load;
  logic              w_is_add;
  logic              w_is_illegal;

  assign instr_ready = (r_state == FETCH) && rst_n;
  assign w_accept = instr_valid && instr_ready;

  // decode the incoming word while fetching,
  // the held instruction afterwards
  assign w_op = (r_state == FETCH)
              ? instr_data[IW-1:DATA_W]
              : r_ir[IW-1:DATA_W];

  td4_op_decode u_dec (
    .i_op         (w_op),
    .i_carry      (r_carry),
    .o_sel        (w_sel),
    .o_load       (w_load),
    .o_is_add     (w_is_add),
    .o_is_illegal (w_is_illegal)
  );

  // sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:  if (w_accept) r_state <= DECODE;
        DECODE: r_state <= EXEC;
        EXEC: begin
          if (r_illegal && ILLEGAL_TRAP)
            r_state <= HALT;
          else
            r_state <= FETCH;
        end
        default: r_state <= HALT;
      endcase
    end
  end

  // instruction register and ALU select,
  // captured on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= '0;
      r_sel <= SEL_A;
    end else if (w_accept) begin
      r_ir <= instr_data;
      r_sel <= w_sel;
    end
  end

  // one-cycle execute strobes, armed in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load <= '0;
      r_pc_inc <= 1'b0;
      r_illegal <= 1'b0;
      r_is_add <= 1'b0;
    end else if (r_state == DECODE) begin
      r_load <= w_load;
      r_pc_inc <= ~w_load[LD_PC];
      r_illegal <= w_is_illegal;
      r_is_add <= w_is_add;
    end else begin
      r_load <= '0;
      r_pc_inc <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  // carry flag: ADD captures, legal ops clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (r_state == EXEC) begin
      if (r_is_add)
        r_carry <= carry_in;
      else if (!r_illegal)
        r_carry <= 1'b0;
    end
  end

  assign sel = r_sel;
  assign imm = r_ir[DATA_W-1:0];
  assign load = r_load;
  assign pc_inc = r_pc_inc;
  assign carry_flag = r_carry;
  assign illegal = r_illegal;
  assign halted = (r_state == HALT);

endmodule

// File: tb/tb_td4_ctrl_seq.sv
// tb_td4_ctrl_seq: directed stimulus with a
// queue scoreboard checking EXEC strobes.
module tb_td4_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       v0 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic       c0 = 1'b0;
  logic       r0, pc0, cf0, il0, h0;
  logic [1:0] sel0;
  logic [3:0] imm0, ld0;

  logic       v1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       c1 = 1'b0;
  logic       r1, pc1, cf1, il1, h1;
  logic [1:0] sel1;
  logic [3:0] imm1, ld1;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] imm;
    logic [3:0] ld;
    logic       pc;
    logic       il;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  td4_ctrl_seq #(.DATA_W(4), .ILLEGAL_TRAP(1'b0)) u0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (v0),
    .instr_data  (d0),
    .instr_ready (r0),
    .carry_in    (c0),
    .sel         (sel0),
    .imm         (imm0),
    .load        (ld0),
    .pc_inc      (pc0),
    .carry_flag  (cf0),
    .illegal     (il0),
    .halted      (h0)
  );

  td4_ctrl_seq #(.DATA_W(4), .ILLEGAL_TRAP(1'b1)) u1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (v1),
    .instr_data  (d1),
    .instr_ready (r1),
    .carry_in    (c1),
    .sel         (sel1),
    .imm         (imm1),
    .load        (ld1),
    .pc_inc      (pc1),
    .carry_flag  (cf1),
    .illegal     (il1),
    .halted      (h1)
  );

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // monitor: every EXEC cycle shows a load or pc_inc
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (rst_n && (ld0 != 4'b0000 || pc0)) begin
      a = {sel0, imm0, ld0, pc0, il0};
      checks++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL exec_unexpected: got %h expected none",
                 a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errs++;
          $display("FAIL exec: got sel=%b imm=%h ld=%b pc=%b il=%b expected sel=%b imm=%h ld=%b pc=%b il=%b",
                   a.sel, a.imm, a.ld, a.pc, a.il,
                   e.sel, e.imm, e.ld, e.pc, e.il);
        end
      end
    end
  end

  // one full instruction on u0; entered #1 after a FETCH edge
  task automatic issue(input logic [7:0] ins,
                       input logic       cin,
                       input logic [1:0] es,
                       input logic [3:0] el,
                       input logic       ep,
                       input logic       ei,
                       input logic       ec);
    logic [3:0] im;
    im = ins[3:0];
    chk("fetch_ready", 8'(r0), 8'd1);
    q.push_back({es, im, el, ep, ei});
    v0 = 1'b1;
    d0 = ins;
    @(posedge clk); #1;
    v0 = 1'b0;
    d0 = ~ins;
    chk("dec_sel", 8'(sel0), 8'(es));
    chk("dec_imm", 8'(imm0), 8'(im));
    chk("dec_ready", 8'(r0), 8'd0);
    c0 = cin;
    @(posedge clk); #1;
    chk("exec_sel", 8'(sel0), 8'(es));
    @(posedge clk); #1;
    c0 = 1'b0;
    chk("carry_after", 8'(cf0), 8'(ec));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_ready", 8'(r0), 8'd0);
    chk("rst_sel", 8'(sel0), 8'd0);
    chk("rst_imm", 8'(imm0), 8'd0);
    chk("rst_load", 8'(ld0), 8'd0);
    chk("rst_pc", 8'(pc0), 8'd0);
    chk("rst_carry", 8'(cf0), 8'd0);
    chk("rst_ill", 8'(il0), 8'd0);
    chk("rst_halt", 8'(h0), 8'd0);
    chk("rst_ready1", 8'(r1), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'h33, 1'b0, 2'b11, 4'b0001, 1'b1, 1'b0, 1'b0);
    issue(8'h0F, 1'b1, 2'b00, 4'b0001, 1'b1, 1'b0, 1'b1);
    issue(8'hE5, 1'b0, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b0);
    issue(8'hE5, 1'b0, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0);
    issue(8'h52, 1'b1, 2'b01, 4'b0010, 1'b1, 1'b0, 1'b1);
    issue(8'h8A, 1'b0, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1);
    issue(8'h97, 1'b1, 2'b01, 4'b0100, 1'b1, 1'b0, 1'b0);
    issue(8'h20, 1'b1, 2'b10, 4'b0001, 1'b1, 1'b0, 1'b0);
    issue(8'h40, 1'b0, 2'b00, 4'b0010, 1'b1, 1'b0, 1'b0);
    issue(8'hFC, 1'b0, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0);
    issue(8'h10, 1'b0, 2'b01, 4'b0001, 1'b1, 1'b0, 1'b0);
    issue(8'h60, 1'b0, 2'b10, 4'b0010, 1'b1, 1'b0, 1'b0);
    issue(8'hB9, 1'b0, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0);
    issue(8'h7E, 1'b0, 2'b11, 4'b0010, 1'b1, 1'b0, 1'b0);
    issue(8'hC0, 1'b0, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0);

    d0 = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ready", 8'(r0), 8'd1);
      chk("bp_load", 8'(ld0), 8'd0);
      chk("bp_pc", 8'(pc0), 8'd0);
      chk("bp_ill", 8'(il0), 8'd0);
      chk("bp_sel", 8'(sel0), 8'd3);
      chk("bp_imm", 8'(imm0), 8'd0);
    end
    issue(8'h33, 1'b0, 2'b11, 4'b0001, 1'b1, 1'b0, 1'b0);

    chk("trap_ready", 8'(r1), 8'd1);
    v1 = 1'b1;
    d1 = 8'h8A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("trap_ill", 8'(il1), 8'd1);
    chk("trap_load", 8'(ld1), 8'd0);
    @(posedge clk); #1;
    chk("trap_halt", 8'(h1), 8'd1);
    chk("trap_ready_lo", 8'(r1), 8'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("trap_stuck", 8'(h1), 8'd1);
    chk("trap_stuck_rdy", 8'(r1), 8'd0);
    chk("trap_stuck_ld", 8'(ld1), 8'd0);
    v1 = 1'b0;

    issue(8'h01, 1'b1, 2'b00, 4'b0001, 1'b1, 1'b0, 1'b1);
    v0 = 1'b1;
    d0 = 8'h73;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    chk("mid_load", 8'(ld0), 8'b0010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_load", 8'(ld0), 8'd0);
    chk("mid_rst_pc", 8'(pc0), 8'd0);
    chk("mid_rst_rdy", 8'(r0), 8'd0);
    chk("mid_rst_cf", 8'(cf0), 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", 8'(r0), 8'd1);
    chk("post_rst_cf", 8'(cf0), 8'd0);
    chk("post_rst_ld", 8'(ld0), 8'd0);
    chk("post_rst_h1", 8'(h1), 8'd0);
    chk("post_rst_r1", 8'(r1), 8'd1);
    issue(8'h73, 1'b0, 2'b11, 4'b0010, 1'b1, 1'b0, 1'b0);

    chk("sb_drain", 8'(q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/td4_ctrl_seq.md
# td4_ctrl_seq

Parametrised, sequenced control unit for the TD4-style CPU core. It accepts one instruction at a time from instruction memory over a valid/ready handshake and decodes it into ALU-input select, register load enables and a PC-increment strobe. It holds the architectural carry flag internally and flags illegal opcodes. It sits between the program ROM/PC and the ALU/register file, replacing purely combinational decode with a three-phase fetch/decode/execute sequence.

## Interface
Parameters:
- DATA_W, 4: immediate/data width; instruction width is 4+DATA_W.
- ILLEGAL_TRAP, 0: when 1, an illegal opcode moves the block to HALT; when 0, it executes as a NOP.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- instr_valid  in  1  instruction word presented.
- instr_data  in  4+DATA_W  {opcode[3:0], imm[DATA_W-1:0]}.
- instr_ready  out  1  block accepts instruction this cycle.
- carry_in  in  1  ALU carry-out, sampled in EXEC.
- sel  out  2  ALU input select: 00 reg A, 01 reg B, 10 input port, 11 zero.
- imm  out  DATA_W  registered immediate operand.
- load  out  4  active-high write enables {pc, out_port, reg_b, reg_a}; nonzero only in EXEC.
- pc_inc  out  1  PC increment strobe, EXEC only.
- carry_flag  out  1  architectural carry flag.
- illegal  out  1  one-cycle pulse in EXEC for an undefined opcode.
- halted  out  1  high in HALT.

## Operation
- Opcodes and actions: 0011 MOV A,Im (sel 11, load A); 0111 MOV B,Im (11, B); 0001 MOV A,B (01, A); 0100 MOV B,A (00, B); 0000 ADD A,Im (00, A); 0101 ADD B,Im (01, B); 0010 IN A (10, A); 0110 IN B (10, B); 1011 OUT Im (11, out); 1001 OUT B (01, out); 1111 JMP Im (11, pc); 1110 JNC Im (11, pc if carry_flag==0, else no load).
- All other opcodes are illegal: sel=11, load=0000, illegal pulses.
- pc_inc=1 in EXEC unless load[3] is set. A taken jump loads the PC and does not increment it.
- Carry: ADD sets carry_flag <= carry_in at the EXEC clock edge. Every other legal opcode, including JNC, clears it. Illegal opcodes leave it unchanged.
- The JNC decision uses carry_flag as it stood before this instruction's EXEC edge.
- imm is passed through unmodified, DATA_W bits wide. No sign or zero extension.
- States: FETCH → DECODE (on instr_valid && instr_ready) → EXEC → FETCH.
- In EXEC, an illegal opcode with ILLEGAL_TRAP=1 goes to HALT instead of FETCH. HALT is left only by reset.

## Timing
- Reset (async assert): state=FETCH; sel=00, imm=0, load=0000, pc_inc=0, carry_flag=0, illegal=0, halted=0. instr_ready=0 while rst_n is low.
- instr_ready = (state==FETCH) && rst_n. It is combinational from the state register.
- The instruction is captured into the instruction register on the accepting edge.
- sel and imm are valid from the DECODE cycle and hold through EXEC. This gives the ALU a full settling cycle.
- load, pc_inc and illegal are asserted for exactly one cycle, in EXEC.
- Throughput is one instruction per 3 clocks, with instr_valid high continuously.
- instr_valid low in FETCH: stay in FETCH, all strobes 0, sel/imm hold their last values.
- instr_data is ignored outside FETCH.
- Reset asserted in any state, including mid-EXEC: outputs go to reset values immediately. The in-flight instruction is discarded with no register write.

## Structure
- Package td4_pkg holds:
  - opcode localparams;
  - sel encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO);
  - load bit indices;
  - the state enum {FETCH, DECODE, EXEC, HALT}.
- Sub-module td4_op_decode is a purely combinational table: opcode, carry_flag → sel, load, is_add, is_illegal.
- Top-level td4_ctrl_seq holds the instruction register, FSM, carry register and output registers.

## Test plan
- Reset then MOV A,3 (0011_0011): instr_ready=1 in cycle 1. DECODE shows sel=11, imm=3. EXEC shows load=0001, pc_inc=1, carry_flag=0.
- ADD A,15 with carry_in=1 in EXEC: carry_flag=1 after EXEC. Then JNC 5: load=0000, pc_inc=1, carry_flag then clears to 0.
- JNC 5 with carry_flag=0: EXEC shows load=1000, imm=5, pc_inc=0.
- Opcode 1000: with ILLEGAL_TRAP=0, illegal=1, load=0000, pc_inc=1, carry_flag unchanged. With ILLEGAL_TRAP=1, halted=1 and instr_ready stays 0 until reset.
- Backpressure: hold instr_valid=0 for 5 cycles in FETCH. The block stays in FETCH with no strobes, then accepts on the first valid cycle.
- Assert rst_n=0 during EXEC of MOV B,Im: load drops to 0000 within the same cycle. After release the block is in FETCH with carry_flag=0.
